// File: rtl/ddr_pkg.sv
// Shared definitions for the Ddr port arbiter: path state encodings, arbitration
// modes and the channel-count to index-width helper.
package ddr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } path_state_e;

    localparam int PRIO_ROUND_ROBIN = 0;
    localparam int PRIO_FIXED       = 1;

    // A single client still carries a 1-bit index so the datapath keeps one shape.
    function automatic int idx_width(input int channels);
        return (channels <= 1) ? 1 : $clog2(channels);
    endfunction

endpackage

// File: rtl/ddr_rr_arbiter.sv
// Combinational winner selection: round-robin from a pointer, or fixed priority
// with the lowest index highest. Produces a one-hot grant and its index.
module ddr_rr_arbiter
    import ddr_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int PRIORITY_MODE = 0,
    localparam int IW           = idx_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [IW-1:0]       ptr,
    output logic [CHANNELS-1:0] grant,
    output logic [IW-1:0]       idx,
    output logic                valid
);

    localparam int SW = IW + 1;
    localparam logic [SW-1:0] CH_V = SW'(CHANNELS);

    logic [IW-1:0]         ptr_eff;
    logic [2*CHANNELS-1:0] rot;
    logic [IW-1:0]         offs;
    logic [SW-1:0]         sum;

    // Rotate the requests so the pointer position lands at bit 0, then take the
    // lowest set bit and rotate the offset back into a client index.
    always_comb begin
        ptr_eff = (PRIORITY_MODE == PRIO_FIXED) ? '0 : ptr;
        rot     = {req, req} >> ptr_eff;
        offs    = '0;
        valid   = 1'b0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (rot[k]) begin
                offs  = IW'(k);
                valid = 1'b1;
            end
        end
        sum = {1'b0, offs} + {1'b0, ptr_eff};
        if (sum >= CH_V) begin
            sum = sum - CH_V;
        end
        idx   = sum[IW-1:0];
        grant = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            grant[k] = valid && (idx == IW'(k));
        end
    end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Multi-client front end for the Ddr core: independent read and write arbitration,
// one outstanding transaction per path, sticky per-path ISSUE timeout flags.
module ddr_port_arbiter
    import ddr_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int ADDR_WIDTH    = 24,
    parameter int DATA_WIDTH    = 16,
    parameter int PRIORITY_MODE = 0,
    parameter int TIMEOUT       = 1024
) (
    input  logic                           clk133_p,
    input  logic                           rst,
    input  logic [CHANNELS-1:0]            chRead,
    input  logic [CHANNELS*ADDR_WIDTH-1:0] chReadAddress,
    output logic [CHANNELS-1:0]            chReadAck,
    output logic [DATA_WIDTH-1:0]          chReadData,
    input  logic [CHANNELS-1:0]            chWrite,
    input  logic [CHANNELS*ADDR_WIDTH-1:0] chWriteAddress,
    input  logic [CHANNELS*DATA_WIDTH-1:0] chWriteData,
    output logic [CHANNELS-1:0]            chWriteAck,
    output logic                           read,
    output logic [ADDR_WIDTH-1:0]          readAddress,
    input  logic                           readAcknowledge,
    input  logic [DATA_WIDTH-1:0]          readData,
    output logic                           write,
    output logic [ADDR_WIDTH-1:0]          writeAddress,
    output logic [DATA_WIDTH-1:0]          writeData,
    input  logic                           writeAcknowledge,
    output logic [1:0]                     timeoutError
);

    localparam int IW = idx_width(CHANNELS);
    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] i);
        return (i == IW'(CHANNELS - 1)) ? '0 : i + 1'b1;
    endfunction

    function automatic logic [CHANNELS-1:0] onehot(input logic [IW-1:0] i);
        logic [CHANNELS-1:0] v;
        for (int k = 0; k < CHANNELS; k++) begin
            v[k] = (i == IW'(k));
        end
        return v;
    endfunction

    path_state_e           rd_st_q, rd_st_d, wr_st_q, wr_st_d;
    logic [IW-1:0]         rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d;
    logic [IW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic                  read_q, read_d, write_q, write_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d, wr_data_q, wr_data_d;
    logic [CHANNELS-1:0]   rd_ack_q, rd_ack_d, wr_ack_q, wr_ack_d;
    logic [TW-1:0]         rd_tmr_q, rd_tmr_d, wr_tmr_q, wr_tmr_d;
    logic                  rd_err_q, rd_err_d, wr_err_q, wr_err_d;

    logic [CHANNELS-1:0]   rd_grant, wr_grant;
    logic [IW-1:0]         rd_win, wr_win;
    logic                  rd_any, wr_any;
    logic [ADDR_WIDTH-1:0] rd_win_addr, wr_win_addr;
    logic [DATA_WIDTH-1:0] wr_win_data;

    ddr_rr_arbiter #(.CHANNELS(CHANNELS), .PRIORITY_MODE(PRIORITY_MODE)) u_rd_arb (
        .req(chRead), .ptr(rd_ptr_q), .grant(rd_grant), .idx(rd_win), .valid(rd_any)
    );

    ddr_rr_arbiter #(.CHANNELS(CHANNELS), .PRIORITY_MODE(PRIORITY_MODE)) u_wr_arb (
        .req(chWrite), .ptr(wr_ptr_q), .grant(wr_grant), .idx(wr_win), .valid(wr_any)
    );

    always_comb begin
        rd_win_addr = '0;
        wr_win_addr = '0;
        wr_win_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (rd_grant[k]) rd_win_addr = chReadAddress[k*ADDR_WIDTH +: ADDR_WIDTH];
            if (wr_grant[k]) wr_win_addr = chWriteAddress[k*ADDR_WIDTH +: ADDR_WIDTH];
            if (wr_grant[k]) wr_win_data = chWriteData[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Read path. The ISSUE timer falls back to zero in every other state.
    always_comb begin
        rd_st_d   = rd_st_q;
        rd_idx_d  = rd_idx_q;
        rd_ptr_d  = rd_ptr_q;
        read_d    = read_q;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        rd_ack_d  = '0;
        rd_tmr_d  = '0;
        rd_err_d  = rd_err_q;
        case (rd_st_q)
            ST_IDLE: if (rd_any) begin
                rd_st_d   = ST_ISSUE;
                rd_idx_d  = rd_win;
                rd_addr_d = rd_win_addr;
                read_d    = 1'b1;
                if (PRIORITY_MODE == PRIO_ROUND_ROBIN) rd_ptr_d = next_ptr(rd_win);
            end
            ST_ISSUE: if (readAcknowledge) begin
                rd_st_d   = ST_DONE;
                read_d    = 1'b0;
                rd_ack_d  = onehot(rd_idx_q);
                rd_data_d = readData;
            end else begin
                rd_tmr_d = (rd_tmr_q == TMAX) ? rd_tmr_q : rd_tmr_q + 1'b1;
                if (TIMEOUT != 0 && rd_tmr_d == TMAX) rd_err_d = 1'b1;
            end
            default: rd_st_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_st_d   = wr_st_q;
        wr_idx_d  = wr_idx_q;
        wr_ptr_d  = wr_ptr_q;
        write_d   = write_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_ack_d  = '0;
        wr_tmr_d  = '0;
        wr_err_d  = wr_err_q;
        case (wr_st_q)
            ST_IDLE: if (wr_any) begin
                wr_st_d   = ST_ISSUE;
                wr_idx_d  = wr_win;
                wr_addr_d = wr_win_addr;
                wr_data_d = wr_win_data;
                write_d   = 1'b1;
                if (PRIORITY_MODE == PRIO_ROUND_ROBIN) wr_ptr_d = next_ptr(wr_win);
            end
            ST_ISSUE: if (writeAcknowledge) begin
                wr_st_d  = ST_DONE;
                write_d  = 1'b0;
                wr_ack_d = onehot(wr_idx_q);
            end else begin
                wr_tmr_d = (wr_tmr_q == TMAX) ? wr_tmr_q : wr_tmr_q + 1'b1;
                if (TIMEOUT != 0 && wr_tmr_d == TMAX) wr_err_d = 1'b1;
            end
            default: wr_st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk133_p or negedge rst) begin
        if (!rst) begin
            rd_st_q   <= ST_IDLE;
            wr_st_q   <= ST_IDLE;
            rd_idx_q  <= '0;
            wr_idx_q  <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            rd_data_q <= '0;
            wr_data_q <= '0;
            rd_ack_q  <= '0;
            wr_ack_q  <= '0;
            rd_tmr_q  <= '0;
            wr_tmr_q  <= '0;
            rd_err_q  <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            rd_st_q   <= rd_st_d;
            wr_st_q   <= wr_st_d;
            rd_idx_q  <= rd_idx_d;
            wr_idx_q  <= wr_idx_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            read_q    <= read_d;
            write_q   <= write_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            rd_data_q <= rd_data_d;
            wr_data_q <= wr_data_d;
            rd_ack_q  <= rd_ack_d;
            wr_ack_q  <= wr_ack_d;
            rd_tmr_q  <= rd_tmr_d;
            wr_tmr_q  <= wr_tmr_d;
            rd_err_q  <= rd_err_d;
            wr_err_q  <= wr_err_d;
        end
    end

    assign read         = read_q;
    assign readAddress  = rd_addr_q;
    assign chReadAck    = rd_ack_q;
    assign chReadData   = rd_data_q;
    assign write        = write_q;
    assign writeAddress = wr_addr_q;
    assign writeData    = wr_data_q;
    assign chWriteAck   = wr_ack_q;
    assign timeoutError = {wr_err_q, rd_err_q};

endmodule
